// File: rtl/relay_frame_ctrl_pkg.sv
// Shared definitions for the relay framing controller.
// Holds the modulation codes driven into hi_iso14443a, default frame
// patterns, the selftest ROM pattern and the FSM state type.
package relay_frame_ctrl_pkg;

  // Modulation codes (cfg_mod / mod_type encoding).
  localparam logic [2:0] ModSniffer      = 3'b000;
  localparam logic [2:0] ModTagListen    = 3'b001;
  localparam logic [2:0] ModReaderMod    = 3'b010;
  localparam logic [2:0] ModReaderListen = 3'b011;
  localparam logic [2:0] ModTagMod       = 3'b100;
  localparam logic [2:0] ModFakeReader   = 3'b101;
  localparam logic [2:0] ModFakeTag      = 3'b110;

  // Default frame patterns.
  localparam logic [7:0]  DefRdStart = 8'hC0;
  localparam logic [15:0] DefRdEndA  = 16'h0000;
  localparam logic [15:0] DefRdEndB  = 16'hC000;
  localparam logic [7:0]  DefTgStart = 8'hF0;
  localparam logic [7:0]  DefTgEnd   = 8'h00;

  // Selftest pattern, emitted MSB first.
  localparam int unsigned    SelftestLen     = 80;
  localparam logic [79:0]    SelftestPattern = 80'hc0c00c00c00c000c0000;

  typedef enum logic [1:0] {
    StIdle,
    StListen,
    StActive
  } state_e;

  function automatic logic [2:0] listen_code(input logic is_reader);
    return is_reader ? ModReaderListen : ModTagListen;
  endfunction

  function automatic logic [2:0] active_code(input logic is_reader);
    return is_reader ? ModReaderMod : ModTagMod;
  endfunction

endpackage

// File: rtl/relay_pattern_gen.sv
// Selftest bit source for the relay framing controller.
// Built only when RELAY_SELFTEST_EN is defined; otherwise this file is empty.
// Ports:
//   ck   in  clock
//   rst  in  synchronous active-high reset (also pulsed on role entry)
//   step in  advance to the next pattern bit
//   dout out current pattern bit, MSB of the ROM first, looping
`ifdef RELAY_SELFTEST_EN
module relay_pattern_gen
  import relay_frame_ctrl_pkg::*;
(
  input  logic ck,
  input  logic rst,
  input  logic step,
  output logic dout
);

  logic [6:0] ptr_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (step) begin
      ptr_q <= (ptr_q == 7'(SelftestLen - 1)) ? 7'd0 : ptr_q + 7'd1;
    end
  end

  assign dout = SelftestPattern[7'(SelftestLen - 1) - ptr_q];

endmodule
`endif

// File: rtl/relay_frame_ctrl.sv
// Relay-mode framing controller for the HF path.
// Samples the serial relay link once per bit strobe, detects start and
// end-of-frame patterns in a history shift register and drives mod_type into
// hi_iso14443a. Outside the relay roles the configured mod type passes through.
// Optional feature: RELAY_SELFTEST_EN replaces relay_in with a looping ROM
// pattern from relay_pattern_gen.
// Ports:
//   ck_1356meg    in  13.56 MHz clock
//   rst           in  synchronous active-high reset
//   cfg_mod       in  configured mod type (conf_word[2:0])
//   relay_in      in  serial relay input
//   mod_type      out modulation type to hi_iso14443a
//   relay_data    out history[DATA_TAP] in relay roles, else 0
//   bit_strobe    out 1-cycle pulse per sampled bit
//   frame_active  out high while a frame is in progress
//   frame_timeout out 1-cycle pulse on timeout abort
module relay_frame_ctrl
  import relay_frame_ctrl_pkg::*;
#(
  parameter int unsigned       DIV_W     = 4,
  parameter logic [DIV_W-1:0]  DIV_PHASE = 4'd8,
  parameter int unsigned       HIST_W    = 24,
  parameter int unsigned       DATA_TAP  = 7,
  parameter logic [7:0]        RD_START  = DefRdStart,
  parameter logic [15:0]       RD_END_A  = DefRdEndA,
  parameter logic [15:0]       RD_END_B  = DefRdEndB,
  parameter logic [7:0]        TG_START  = DefTgStart,
  parameter logic [7:0]        TG_END    = DefTgEnd,
  parameter int unsigned       MAX_BITS  = 1024
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic [2:0] cfg_mod,
  input  logic       relay_in,
  output logic [2:0] mod_type,
  output logic       relay_data,
  output logic       bit_strobe,
  output logic       frame_active,
  output logic       frame_timeout
);

  localparam int unsigned      FbW      = $clog2(MAX_BITS + 1);
  localparam logic [FbW-1:0]   MaxBitsC = FbW'(MAX_BITS);

  logic [DIV_W-1:0]  div_q;
  logic [2:0]        cfg_q;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [FbW-1:0]    fbits_q, fbits_d;
  state_e            state_q, state_d;
  logic [2:0]        relay_mod_q, relay_mod_d;
  logic              timeout_q, timeout_d;

  logic              relay_role, is_reader, role_change, sample;
  logic [HIST_W-1:0] hist_shift;
  logic [2:0]        cnt_inc;
  logic [7:0]        start_byte;
  logic              start_hit, end_hit;
  logic [FbW-1:0]    fbits_inc;

  assign relay_role  = (cfg_mod == ModFakeReader) || (cfg_mod == ModFakeTag);
  assign is_reader   = (cfg_mod == ModFakeReader);
  // Any change of cfg_mod into or between relay roles restarts framing.
  assign role_change = relay_role && (cfg_mod != cfg_q);
  assign bit_strobe  = (div_q == DIV_PHASE);

`ifdef RELAY_SELFTEST_EN
  logic gen_bit;

  relay_pattern_gen u_pattern_gen (
    .ck   (ck_1356meg),
    .rst  (rst | role_change),
    .step (bit_strobe),
    .dout (gen_bit)
  );

  assign sample = gen_bit;
`else
  assign sample = relay_in;
`endif

  // Matches look at the history and bit count as they will be after this strobe.
  assign hist_shift = {hist_q[HIST_W-2:0], sample};
  assign cnt_inc    = bit_cnt_q + 3'd1;
  assign start_byte = is_reader ? RD_START : TG_START;
  assign start_hit  = (hist_shift[23:0] == {16'h0000, start_byte});
  assign end_hit    = (cnt_inc == 3'd0) &&
                      (is_reader ? ((hist_shift[23:8] == RD_END_A) ||
                                    (hist_shift[23:8] == RD_END_B))
                                 : (hist_shift[15:8] == TG_END));
  assign fbits_inc  = (fbits_q == MaxBitsC) ? fbits_q : fbits_q + 1'b1;

  always_comb begin
    hist_d      = hist_q;
    bit_cnt_d   = bit_cnt_q;
    fbits_d     = fbits_q;
    state_d     = state_q;
    relay_mod_d = relay_mod_q;
    timeout_d   = 1'b0;

    if (!relay_role) begin
      state_d = StIdle;
    end else if (role_change) begin
      hist_d      = '0;
      bit_cnt_d   = 3'd0;
      fbits_d     = '0;
      state_d     = StListen;
      relay_mod_d = listen_code(is_reader);
    end else if (bit_strobe) begin
      hist_d    = hist_shift;
      bit_cnt_d = cnt_inc;
      // Start wins over end and timeout, and re-arms a frame already running.
      if (start_hit && (state_q != StIdle)) begin
        state_d     = StActive;
        bit_cnt_d   = 3'd0;
        fbits_d     = '0;
        relay_mod_d = active_code(is_reader);
      end else if (state_q == StActive) begin
        fbits_d = fbits_inc;
        if (end_hit) begin
          state_d     = StListen;
          relay_mod_d = listen_code(is_reader);
        end else if (fbits_inc == MaxBitsC) begin
          state_d     = StListen;
          relay_mod_d = listen_code(is_reader);
          timeout_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      div_q       <= '0;
      cfg_q       <= 3'd0;
      hist_q      <= '0;
      bit_cnt_q   <= 3'd0;
      fbits_q     <= '0;
      state_q     <= StIdle;
      relay_mod_q <= ModSniffer;
      timeout_q   <= 1'b0;
    end else begin
      div_q       <= div_q + 1'b1;
      cfg_q       <= cfg_mod;
      hist_q      <= hist_d;
      bit_cnt_q   <= bit_cnt_d;
      fbits_q     <= fbits_d;
      state_q     <= state_d;
      relay_mod_q <= relay_mod_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mod_type      = relay_role ? relay_mod_q : cfg_mod;
  assign relay_data    = relay_role & hist_q[DATA_TAP];
  assign frame_active  = (state_q == StActive);
  assign frame_timeout = timeout_q;

endmodule
